tx_phy_ser: RTL and testbench

- Transmit serializer that consumes the TX controller's grant (tx_phy_start, one-hot tx_phy_sel) and sends one task packet from the TX FIFO to the selected PHY.
- Output is a two-wire return-to-high line pair per PHY.
- Pops 32-bit words from the FIFO and shifts them out MSB first.
- Signals completion back to the controller with tx_phy_done and task_id_vld, which starts that PHY's response timer.

---
 rtl/tx_phy_ser_if.sv | 27 ++
 rtl/tx_phy_ser.sv | 178 +++++++++++++++++
 tb/tb_tx_phy_ser.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tx_phy_ser_if.sv
// Handshake bundle between the TX controller / TX FIFO and the serializer.
//   tx_phy_start/tx_phy_sel : grant pulse and one-hot PHY select from the controller
//   tx_phy_done/task_id_vld : end-of-packet pulses back to the controller
//   fifo_empty/fifo_dout    : TX FIFO status and read data (dout valid 1 cycle after fifo_rd)
//   fifo_rd                 : FIFO pop strobe
// master = controller/FIFO side, slave = serializer.
interface tx_phy_ser_if #(
  parameter int PHY_NUM = 32
);
  logic               tx_phy_start;
  logic [PHY_NUM-1:0] tx_phy_sel;
  logic               tx_phy_done;
  logic               task_id_vld;
  logic               fifo_empty;
  logic [31:0]        fifo_dout;
  logic               fifo_rd;

  modport master (
    output tx_phy_start, tx_phy_sel, fifo_empty, fifo_dout,
    input  tx_phy_done, task_id_vld, fifo_rd
  );

  modport slave (
    input  tx_phy_start, tx_phy_sel, fifo_empty, fifo_dout,
    output tx_phy_done, task_id_vld, fifo_rd
  );
endinterface

// File: rtl/tx_phy_ser.sv
// Transmit serializer: on a controller grant, pops reg_task_words 32-bit words
// from the TX FIFO and shifts them MSB first onto the selected PHY line pairs
// using return-to-high signalling (a '1' pulls tx_p low, a '0' pulls tx_n low
// for the first half of each bit; both lines high for the second half).
// Ports:
//   clk, rst          : clock, async active-low reset
//   reg_flush         : synchronous abort back to IDLE (no done pulse)
//   reg_half_bit      : half-bit period in clk cycles (0 -> 1)
//   reg_task_words    : words per packet (0 -> 1)
//   bus               : controller/FIFO handshake (slave side)
//   tx_p, tx_n        : registered line pairs, idle high
//   busy              : not in IDLE

// Per-PHY line driver. Registered so the line pattern lags the FSM by one cycle.
module tx_phy_lane (
  input  logic clk,
  input  logic rst,
  input  logic flush_i,
  input  logic sel_i,
  input  logic drv_i,
  input  logic bit_i,
  output logic tx_p_o,
  output logic tx_n_o
);
  logic tx_p_q, tx_n_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_p_q <= 1'b1;
      tx_n_q <= 1'b1;
    end else if (flush_i) begin
      tx_p_q <= 1'b1;
      tx_n_q <= 1'b1;
    end else begin
      // only one of the pair can go low since bit_i selects exactly one
      tx_p_q <= ~(sel_i & drv_i & bit_i);
      tx_n_q <= ~(sel_i & drv_i & ~bit_i);
    end
  end

  assign tx_p_o = tx_p_q;
  assign tx_n_o = tx_n_q;
endmodule

module tx_phy_ser #(
  parameter int PHY_NUM = 32,
  parameter int HB_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reg_flush,
  input  logic [HB_W-1:0]    reg_half_bit,
  input  logic [7:0]         reg_task_words,
  tx_phy_ser_if.slave        bus,
  output logic [PHY_NUM-1:0] tx_p,
  output logic [PHY_NUM-1:0] tx_n,
  output logic               busy
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SHIFT, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [PHY_NUM-1:0] sel_q, sel_d;
  logic [7:0]         word_cnt_q, word_cnt_d;
  logic [4:0]         bit_cnt_q, bit_cnt_d;
  logic [HB_W:0]      half_cnt_q, half_cnt_d;
  logic [31:0]        sh_q, sh_d;
  logic               fifo_rd;

  // effective half-bit length and last cycle index of a bit (2*H - 1);
  // one extra bit of width holds 2*H without overflow
  logic [HB_W:0] half_len, bit_end;
  logic [7:0]    last_word;
  logic          low_phase;

  assign half_len  = (reg_half_bit == '0) ? {{HB_W{1'b0}}, 1'b1} : {1'b0, reg_half_bit};
  assign bit_end   = {half_len[HB_W-1:0], 1'b0} - {{HB_W{1'b0}}, 1'b1};
  assign last_word = (reg_task_words == 8'd0) ? 8'd0 : reg_task_words - 8'd1;
  assign low_phase = (state_q == S_SHIFT) && (half_cnt_q < half_len);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      word_cnt_q <= '0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      sh_q       <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      word_cnt_q <= word_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      sh_q       <= sh_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    word_cnt_d = word_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    half_cnt_d = half_cnt_q;
    sh_d       = sh_q;
    fifo_rd    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.tx_phy_start) begin
          sel_d      = bus.tx_phy_sel;
          word_cnt_d = '0;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        // stall here indefinitely while the FIFO is empty
        if (!bus.fifo_empty) begin
          fifo_rd = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        sh_d       = bus.fifo_dout;
        bit_cnt_d  = '0;
        half_cnt_d = '0;
        state_d    = S_SHIFT;
      end
      S_SHIFT: begin
        if (half_cnt_q == bit_end) begin
          half_cnt_d = '0;
          sh_d       = {sh_q[30:0], 1'b0};
          if (bit_cnt_q == 5'd31) begin
            if (word_cnt_q == last_word) begin
              state_d = S_DONE;
            end else begin
              word_cnt_d = word_cnt_q + 8'd1;
              state_d    = S_LOAD;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
        end else begin
          half_cnt_d = half_cnt_q + {{HB_W{1'b0}}, 1'b1};
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (reg_flush) begin
      state_d    = S_IDLE;
      word_cnt_d = '0;
      bit_cnt_d  = '0;
      half_cnt_d = '0;
      fifo_rd    = 1'b0;
    end
  end

  assign bus.fifo_rd     = fifo_rd;
  assign bus.tx_phy_done = (state_q == S_DONE);
  assign bus.task_id_vld = (state_q == S_DONE);
  assign busy            = (state_q != S_IDLE);

  for (genvar i = 0; i < PHY_NUM; i++) begin : g_lane
    tx_phy_lane u_lane (
      .clk    (clk),
      .rst    (rst),
      .flush_i(reg_flush),
      .sel_i  (sel_q[i]),
      .drv_i  (low_phase),
      .bit_i  (sh_q[31]),
      .tx_p_o (tx_p[i]),
      .tx_n_o (tx_n[i])
    );
  end
endmodule

// File: tb/tb_tx_phy_ser.sv
module tb_tx_phy_ser;
  localparam int PHY_NUM = 32;
  localparam int HB_W    = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               reg_flush = 1'b0;
  logic [HB_W-1:0]    reg_half_bit = 16'd2;
  logic [7:0]         reg_task_words = 8'd1;
  logic [PHY_NUM-1:0] tx_p, tx_n;
  logic               busy;

  tx_phy_ser_if #(.PHY_NUM(PHY_NUM)) bus();

  tx_phy_ser #(.PHY_NUM(PHY_NUM), .HB_W(HB_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .reg_flush     (reg_flush),
    .reg_half_bit  (reg_half_bit),
    .reg_task_words(reg_task_words),
    .bus           (bus),
    .tx_p          (tx_p),
    .tx_n          (tx_n),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // FIFO model: dout valid the cycle after a pop
  logic [31:0] fifo_mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd && (wr_ptr != rd_ptr)) begin
      bus.fifo_dout <= fifo_mem[rd_ptr % 64];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  // scoreboard of expected line bits (1 = tx_p pulse, 0 = tx_n pulse)
  bit exp_q[$];
  int mon_phy   = -1;
  int h_exp     = 1;
  int run       = 0;
  bit run_is_p  = 1'b0;
  int bit_idx   = 0;
  int last_start = 0;
  int lcyc      = 0;

  task automatic push_word(input logic [31:0] w, input bit track);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr++;
    if (track) for (int b = 31; b >= 0; b--) exp_q.push_back(w[b]);
  endtask

  // advance one cycle, then decode the monitored PHY and compare against the scoreboard
  task automatic step();
    bit bad, lo_p, lo_n, e;
    @(posedge clk); #1;
    lcyc++;
    bad = 1'b0;
    for (int i = 0; i < PHY_NUM; i++) begin
      if (!tx_p[i] && !tx_n[i]) bad = 1'b1;
      if (i != mon_phy && !(tx_p[i] && tx_n[i])) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL line_idle: tx_p=%h tx_n=%h monitored_phy=%0d", tx_p, tx_n, mon_phy);
    end
    if (mon_phy >= 0) begin
      lo_p = !tx_p[mon_phy];
      lo_n = !tx_n[mon_phy];
      if (lo_p || lo_n) begin
        if (run == 0) begin
          run_is_p = lo_p;
          if (bit_idx % 32 != 0) begin
            checks++;
            if ((lcyc - last_start) !== 2 * h_exp) begin
              errors++;
              $display("FAIL bit_period: bit %0d got %0d cycles want %0d", bit_idx, lcyc - last_start, 2 * h_exp);
            end
          end
          last_start = lcyc;
        end
        run++;
      end else if (run > 0) begin
        checks++;
        if (run !== h_exp) begin
          errors++;
          $display("FAIL low_len: bit %0d got %0d want %0d", bit_idx, run, h_exp);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bit_val: bit %0d got unexpected bit want none", bit_idx);
        end else begin
          e = exp_q.pop_front();
          if (run_is_p !== e) begin
            errors++;
            $display("FAIL bit_val: bit %0d got %0b want %0b", bit_idx, run_is_p, e);
          end
        end
        bit_idx++;
        run = 0;
      end
    end
  endtask

  task automatic start_pkt(input logic [PHY_NUM-1:0] sel);
    bus.tx_phy_sel   = sel;
    bus.tx_phy_start = 1'b1;
    step();
    bus.tx_phy_start = 1'b0;
    bus.tx_phy_sel   = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus.tx_phy_start = ~bus.tx_phy_start;
      bus.tx_phy_sel   = 32'h0000_FFFF;
      step();
      checks++; if (tx_p !== '1) begin errors++; $display("FAIL reset_tx_p: got %h want all ones", tx_p); end
      checks++; if (tx_n !== '1) begin errors++; $display("FAIL reset_tx_n: got %h want all ones", tx_n); end
      checks++; if (bus.fifo_rd !== 1'b0) begin errors++; $display("FAIL reset_fifo_rd: got %b want 0", bus.fifo_rd); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    end
    bus.tx_phy_start = 1'b0;
    bus.tx_phy_sel   = '0;
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (busy !== 1'b0 || bus.fifo_rd !== 1'b0 || bus.tx_phy_done !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_quiet: busy=%b fifo_rd=%b done=%b want 0", busy, bus.fifo_rd, bus.tx_phy_done);
      end
    end
  endtask

  task automatic test_single();
    int cyc, rd;
    reg_half_bit = 16'd2; reg_task_words = 8'd1;
    h_exp = 2; mon_phy = 3; bit_idx = 0; run = 0;
    push_word(32'hA500_0001, 1'b1);
    start_pkt(32'h8);
    checks++; if (bus.fifo_rd !== 1'b1) begin errors++; $display("FAIL single_first_rd: got %b want 1", bus.fifo_rd); end
    rd = int'(bus.fifo_rd); cyc = 0;
    while (!bus.tx_phy_done && cyc < 400) begin step(); cyc++; rd += int'(bus.fifo_rd); end
    checks++; if (cyc !== 130) begin errors++; $display("FAIL single_done_latency: got %0d want 130", cyc); end
    checks++; if (bus.task_id_vld !== 1'b1) begin errors++; $display("FAIL single_task_id_vld: got %b want 1", bus.task_id_vld); end
    checks++; if (rd !== 1) begin errors++; $display("FAIL single_rd_count: got %0d want 1", rd); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL single_bits_left: got %0d want 0", exp_q.size()); end
    step();
    checks++;
    if (bus.tx_phy_done !== 1'b0 || bus.task_id_vld !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done_width: done=%b vld=%b busy=%b want 0", bus.tx_phy_done, bus.task_id_vld, busy);
    end
    mon_phy = -1;
  endtask

  task automatic test_multi_stall();
    int cyc, rd;
    reg_half_bit = 16'd1; reg_task_words = 8'd3;
    h_exp = 1; mon_phy = 5; bit_idx = 0; run = 0;
    push_word(32'hDEAD_BEEF, 1'b1);
    push_word(32'h0F0F_00FF, 1'b1);
    start_pkt(32'h20);
    rd = int'(bus.fifo_rd); cyc = 0;
    while (rd < 2 && cyc < 400) begin step(); cyc++; rd += int'(bus.fifo_rd); end
    repeat (66) begin step(); cyc++; rd += int'(bus.fifo_rd); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (busy !== 1'b1 || bus.fifo_rd !== 1'b0 || tx_p !== '1 || tx_n !== '1) begin
        errors++;
        $display("FAIL stall_hold: k=%0d busy=%b fifo_rd=%b tx_p=%h tx_n=%h want busy 1, rd 0, lines high", k, busy, bus.fifo_rd, tx_p, tx_n);
      end
      if (k < 9) begin step(); cyc++; rd += int'(bus.fifo_rd); end
    end
    push_word(32'h8000_0001, 1'b1);
    #1; rd += int'(bus.fifo_rd);
    while (!bus.tx_phy_done && cyc < 600) begin step(); cyc++; rd += int'(bus.fifo_rd); end
    checks++; if (cyc !== 207) begin errors++; $display("FAIL multi_done_latency: got %0d want 207", cyc); end
    checks++; if (rd !== 3) begin errors++; $display("FAIL multi_rd_count: got %0d want 3", rd); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL multi_bits_left: got %0d want 0", exp_q.size()); end
    step();
    mon_phy = -1;
  endtask

  task automatic test_flush();
    int cyc, dn;
    reg_half_bit = 16'd2; reg_task_words = 8'd1;
    h_exp = 2; mon_phy = 0; bit_idx = 0; run = 0;
    push_word(32'h1234_5678, 1'b1);
    start_pkt(32'h1);
    cyc = 0;
    while (bit_idx < 10 && cyc < 400) begin step(); cyc++; end
    step(); step();
    reg_flush = 1'b1;
    mon_phy = -1; run = 0; exp_q.delete();
    step();
    reg_flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy); end
    checks++; if (tx_p !== '1 || tx_n !== '1) begin errors++; $display("FAIL flush_lines: tx_p=%h tx_n=%h want all ones", tx_p, tx_n); end
    dn = int'(bus.tx_phy_done);
    repeat (20) begin step(); dn += int'(bus.tx_phy_done); end
    checks++; if (dn !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", dn); end
    mon_phy = 0; bit_idx = 0; run = 0;
    push_word(32'h0000_FFFF, 1'b1);
    start_pkt(32'h1);
    cyc = 0;
    while (!bus.tx_phy_done && cyc < 400) begin step(); cyc++; end
    checks++; if (cyc !== 130) begin errors++; $display("FAIL flush_restart_latency: got %0d want 130", cyc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL flush_restart_bits: got %0d want 0", exp_q.size()); end
    step();
    mon_phy = -1;
  endtask

  task automatic test_boundary();
    int cyc, rd;
    reg_half_bit = 16'd0; reg_task_words = 8'd0;
    h_exp = 1; mon_phy = 31; bit_idx = 0; run = 0;
    push_word(32'h3C3C_5AA5, 1'b1);
    start_pkt(32'h8000_0000);
    rd = int'(bus.fifo_rd); cyc = 0;
    while (!bus.tx_phy_done && cyc < 400) begin step(); cyc++; rd += int'(bus.fifo_rd); end
    checks++; if (cyc !== 66) begin errors++; $display("FAIL boundary_latency: got %0d want 66", cyc); end
    checks++; if (rd !== 1) begin errors++; $display("FAIL boundary_rd_count: got %0d want 1", rd); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL boundary_bits_left: got %0d want 0", exp_q.size()); end
    step();
    mon_phy = -1;
  endtask

  task automatic test_back_to_back();
    int cyc, rd;
    reg_half_bit = 16'd1; reg_task_words = 8'd1;
    h_exp = 1; mon_phy = 2; bit_idx = 0; run = 0;
    push_word(32'hC001_D00D, 1'b1);
    push_word(32'h5555_AAAA, 1'b1);
    start_pkt(32'h4);
    rd = int'(bus.fifo_rd); cyc = 0;
    while (!bus.tx_phy_done && cyc < 400) begin
      step(); cyc++; rd += int'(bus.fifo_rd);
      if (cyc == 10) begin bus.tx_phy_start = 1'b1; bus.tx_phy_sel = 32'h10; end
      else begin bus.tx_phy_start = 1'b0; bus.tx_phy_sel = '0; end
    end
    checks++; if (cyc !== 66) begin errors++; $display("FAIL b2b_first_latency: got %0d want 66", cyc); end
    checks++; if (rd !== 1) begin errors++; $display("FAIL b2b_ignored_start: got %0d reads want 1", rd); end
    step();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_after_done: got %b want 0", busy); end
    start_pkt(32'h4);
    checks++; if (bus.fifo_rd !== 1'b1) begin errors++; $display("FAIL b2b_second_rd: got %b want 1", bus.fifo_rd); end
    cyc = 0;
    while (!bus.tx_phy_done && cyc < 400) begin step(); cyc++; end
    checks++; if (cyc !== 66) begin errors++; $display("FAIL b2b_second_latency: got %0d want 66", cyc); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL b2b_bits_left: got %0d want 0", exp_q.size()); end
    step();
    mon_phy = -1;
  endtask

  initial begin
    bus.tx_phy_start = 1'b0;
    bus.tx_phy_sel   = '0;
    test_reset();
    test_single();
    test_multi_stall();
    test_flush();
    test_boundary();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
